// File: rtl/inst_cache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains above byte offset, word select and index.
  function automatic int tag_w(input int line_words, input int lines);
    return 30 - $clog2(line_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Data and tag storage: combinational read, one write port (word plus tag).
module inst_cache_array #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64,
  parameter int WORD_W     = 2,
  parameter int INDEX_W    = 6,
  parameter int TAG_W      = 22
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  output logic [31:0]        rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [31:0]        wr_data,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [31:0]      data_mem [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];

  // The tag is rewritten with every word; the line stays invalid until the last one.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
      tag_mem[wr_index]             <= wr_tag;
    end
  end

  assign rd_data = data_mem[{rd_index, rd_word}];
  assign rd_tag  = tag_mem[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, whole-line refill
// over a req/ack word bus. mem_req/mem_ack: a word is accepted in a cycle where both are high.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_din,
  output state_t      fsm_state
);

  localparam int WORD_W  = word_w(LINE_WORDS);
  localparam int INDEX_W = index_w(LINES);
  localparam int TAG_W   = tag_w(LINE_WORDS, LINES);

  logic [WORD_W-1:0]  word;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               unused_bits;

  state_t             state, next_state;
  logic [WORD_W-1:0]  cnt;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [LINES-1:0]   valid;
  logic               no_val;

  logic [31:0]        rd_data;
  logic [TAG_W-1:0]   rd_tag;
  logic               hit, accept, last;

  assign word        = inst_addr[2 +: WORD_W];
  assign index       = inst_addr[2+WORD_W +: INDEX_W];
  assign tag         = inst_addr[31 -: TAG_W];
  assign unused_bits = ^inst_addr[1:0];

  inst_cache_array #(
    .LINE_WORDS(LINE_WORDS), .LINES(LINES),
    .WORD_W(WORD_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W)
  ) u_array (
    .clk     (clk),
    .rd_index(index),
    .rd_word (word),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .we      (accept),
    .wr_index(fill_index),
    .wr_word (cnt),
    .wr_data (mem_din),
    .wr_tag  (fill_tag)
  );

  assign hit        = inst_ren && valid[index] && (rd_tag == tag) && (state == IDLE);
  assign inst_stall = inst_ren && !hit;
  assign inst_data  = hit ? rd_data : 32'd0;
  assign accept     = (state == FILL) && mem_req && mem_ack;
  assign last       = (cnt == WORD_W'(LINE_WORDS - 1));
  assign fsm_state  = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (inst_ren && !hit) next_state = FILL;
      FILL:    if (accept && last)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
      cnt        <= '0;
      no_val     <= 1'b0;
      fill_index <= '0;
      fill_tag   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (next_state == FILL) begin
            fill_index   <= index;
            fill_tag     <= tag;
            cnt          <= '0;
            mem_req      <= 1'b1;
            mem_addr     <= {tag, index, {(WORD_W+2){1'b0}}};
            valid[index] <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            if (last) begin
              mem_req <= 1'b0;
              if (!no_val && !flush) valid[fill_index] <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
      // Flush wins over any validate in the same cycle.
      if (flush) valid <= '0;
      if ((state == FILL) && (next_state == IDLE)) no_val <= 1'b0;
      else if ((state == FILL) && flush)           no_val <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache with a reactive memory model and address/data scoreboards.
module tb_inst_cache;
  import inst_cache_pkg::*;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_din;
  state_t      fsm_state;

  logic        auto_mem = 1'b1;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_din = 32'd0;
  logic        man_ack  = 1'b0;
  logic [31:0] man_din  = 32'd0;
  int          wait_n   = 0;
  int          wc       = 0;
  logic [31:0] held_addr = 32'd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_data_q[$];

  assign mem_ack = auto_mem ? resp_ack : man_ack;
  assign mem_din = auto_mem ? resp_din : man_din;

  inst_cache #(.LINE_WORDS(LW), .LINES(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .inst_stall(inst_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_din   (mem_din),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'(LW*4 - 1);
    for (int i = 0; i < LW; i++) exp_q.push_back(base + 32'(4*i));
  endtask

  // Memory responder: acks after wait_n idle cycles, scoreboards each accepted address.
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (auto_mem && mem_req && !rst) begin
      if (wc == 0) held_addr = mem_addr;
      else check("addr_stable", mem_addr, held_addr);
      if (wc == wait_n) begin
        resp_ack = 1'b1;
        resp_din = model(mem_addr);
        wc = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL req_unexpected got=%h want=none", mem_addr);
        end else begin
          check("req_addr", mem_addr, exp_q.pop_front());
        end
      end else begin
        wc++;
      end
    end else begin
      wc = 0;
    end
  end

  task automatic do_fetch(input logic [31:0] a, input int exp_stalls);
    int stalls;
    bit done;
    stalls = 0;
    done = 0;
    if (exp_stalls > 0) push_line(a);
    exp_data_q.push_back(model(a));
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      inst_ren  = 1'b1;
      inst_addr = a;
      #1;
      if (inst_stall) begin
        stalls++;
        check("stall_data_zero", inst_data, 32'd0);
      end else begin
        done = 1;
        check("fetch_data", inst_data, exp_data_q.pop_front());
        if (exp_stalls == 0) check("hit_no_req", {31'd0, mem_req}, 32'd0);
      end
    end
    check("fetch_done", {31'd0, done}, 32'd1);
    check("stall_cycles", stalls, exp_stalls);
    inst_ren = 1'b0;
  endtask

  initial begin
    int cyc;
    int stalls;
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", {31'd0, fsm_state}, {31'd0, IDLE});
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_stall_idle", {31'd0, inst_stall}, 32'd0);
    inst_ren = 1'b1;
    #1;
    check("rst_stall_ren", {31'd0, inst_stall}, 32'd1);
    check("rst_data", inst_data, 32'd0);
    inst_ren = 1'b0;

    // Cold miss then hits on the rest of the line
    do_fetch(32'h40, 5);
    do_fetch(32'h44, 0);
    do_fetch(32'h48, 0);
    do_fetch(32'h4C, 0);

    // Conflict eviction
    do_fetch(32'h440, 5);
    do_fetch(32'h44C, 0);
    do_fetch(32'h40, 5);

    // Backpressure: 3 wait cycles per word
    wait_n = 3;
    do_fetch(32'h884, 17);
    wait_n = 0;
    do_fetch(32'h888, 0);

    // Flush in IDLE: same-cycle lookup still hits, next fetch misses
    @(negedge clk);
    flush = 1'b1;
    inst_ren = 1'b1;
    inst_addr = 32'h40;
    #1;
    check("flush_same_cycle_stall", {31'd0, inst_stall}, 32'd0);
    check("flush_same_cycle_data", inst_data, model(32'h40));
    @(negedge clk);
    flush = 1'b0;
    inst_ren = 1'b0;
    do_fetch(32'h40, 5);

    // Flush during FILL: refill completes, line stays invalid
    wait_n = 1;
    push_line(32'h300);
    @(negedge clk);
    inst_ren = 1'b1;
    inst_addr = 32'h300;
    @(negedge clk);
    flush = 1'b1;
    inst_ren = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    cyc = 0;
    while (mem_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_fill_done", {31'd0, mem_req}, 32'd0);
    wait_n = 0;
    do_fetch(32'h300, 5);
    do_fetch(32'h300, 0);

    // Address change during FILL: 0x100 line finishes, then 0x200 refills
    push_line(32'h100);
    push_line(32'h200);
    @(negedge clk);
    inst_ren = 1'b1;
    inst_addr = 32'h100;
    #1;
    stalls = inst_stall ? 1 : 0;
    check("chg_first_stall", {31'd0, inst_stall}, 32'd1);
    cyc = 0;
    while (inst_stall && cyc < 100) begin
      @(negedge clk);
      inst_addr = 32'h200;
      #1;
      if (inst_stall) begin
        stalls++;
        check("chg_stall_data_zero", inst_data, 32'd0);
      end
      cyc++;
    end
    check("chg_stall_cycles", stalls, 10);
    check("chg_data", inst_data, model(32'h200));
    inst_ren = 1'b0;
    do_fetch(32'h108, 0);

    // Reset mid-FILL after the 2nd ack; late ack ignored
    auto_mem = 1'b0;
    @(negedge clk);
    inst_ren = 1'b1;
    inst_addr = 32'hC0;
    #1;
    check("rfill_miss", {31'd0, inst_stall}, 32'd1);
    @(negedge clk);
    check("rfill_addr0", mem_addr, 32'hC0);
    man_ack = 1'b1;
    man_din = model(32'hC0);
    @(negedge clk);
    check("rfill_addr1", mem_addr, 32'hC4);
    man_din = model(32'hC4);
    @(negedge clk);
    rst = 1'b1;
    man_din = model(32'hC8);
    @(negedge clk);
    rst = 1'b0;
    inst_ren = 1'b0;
    #1;
    check("rfill_req_low", {31'd0, mem_req}, 32'd0);
    check("rfill_state", {31'd0, fsm_state}, {31'd0, IDLE});
    @(negedge clk);
    #1;
    check("rfill_late_ack_req", {31'd0, mem_req}, 32'd0);
    check("rfill_late_ack_addr", mem_addr, 32'd0);
    man_ack = 1'b0;
    auto_mem = 1'b1;
    do_fetch(32'hC0, 5);
    do_fetch(32'hCC, 0);

    repeat (2) @(negedge clk);
    check("req_queue_empty", exp_q.size(), 32'd0);
    check("data_queue_empty", exp_data_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the pipeline core's instruction-fetch port and the instruction memory bus. It answers fetches from the core with zero-cycle hit latency. On a miss it raises a stall and refills the whole line over a req/ack word bus. The core's IF stage freezes on `inst_stall`; the memory side is a slow, handshaked instruction RAM or ROM.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line, power of two, at least 2.
- `LINES`, default 64: number of lines, power of two.
- `clk`  in  1  main clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high; reset is synchronous and active-high.
- `inst_ren`  in  1  core fetch request for the current cycle.
- `inst_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `inst_data`  out  32  fetched word; valid when `inst_ren && !inst_stall`, else 0.
- `inst_stall`  out  1  core must hold `inst_addr` and not advance IF.
- `flush`  in  1  one-cycle pulse; invalidates every line.
- `mem_req`  out  1  word read request to the memory bus (registered).
- `mem_addr`  out  32  word-aligned refill address (registered).
- `mem_ack`  in  1  word returned on `mem_din` this cycle.
- `mem_din`  in  32  refill data.

## Operation
- Address split: offset = [1:0]; word = next log2(`LINE_WORDS`) bits; index = next log2(`LINES`) bits; tag = remainder. Defaults give word [3:2], index [9:4], tag [31:10] (22 bits).
- Storage per line: valid bit, tag, and `LINE_WORDS` data words.
- Hit = `inst_ren && valid[index] && tag match && state == IDLE`. On a hit, `inst_data` = the stored word combinationally and `inst_stall` = 0.
- `inst_stall` = `inst_ren && !hit`. It therefore stays 1 throughout FILL.
- State machine, two states:
  - IDLE: on a miss, latch line base = {tag, index, 0}, clear word counter, set `mem_req` = 1 and `mem_addr` = line base. Go to FILL.
  - FILL: each cycle with `mem_ack` = 1, write `mem_din` to word[counter] of the latched index. If the counter is not the last word, increment it and set `mem_addr` += 4. On the last word, set `valid[index]` = 1 and store the tag, drop `mem_req`, and go to IDLE.
- During FILL:
  - `mem_req` stays high and `mem_addr` stays stable between acks.
  - `mem_ack` while `mem_req` = 0 is ignored.
  - At most one word is accepted per cycle.
- Refill order is ascending from word 0. There is no critical-word-first and no early restart.
- Line replacement: the old line's valid bit is cleared in the cycle FILL is entered. A partially overwritten line is never reported as a hit.
- `inst_ren` dropping, or `inst_addr` changing, during FILL does not abort the refill. The next lookup after return to IDLE uses the current address.
- Flush:
  - In IDLE, `flush` clears all valid bits at the clock edge. A lookup in the same cycle still uses the pre-flush valid bits.
  - In FILL, `flush` clears all valid bits and sets a sticky no-validate flag. The refill completes on the bus, but the line is not marked valid. The flag clears on return to IDLE.
- Address arithmetic wraps at the line boundary only. The line base is aligned, so `mem_addr` never crosses into the next line.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req` 0, `mem_addr` 0, word counter 0, no-validate flag 0.
  - Consequences: `inst_stall` = `inst_ren` in the first cycle after reset; `inst_data` = 0.
  - Data and tag arrays are not reset.
- Reset mid-FILL: FILL is abandoned immediately and `mem_req` is 0 in the next cycle. The line is not validated. A late `mem_ack` is ignored.
- Hit latency: 0 cycles.
- Miss penalty, zero-wait memory (ack in every FILL cycle):
  - cycle 0: IDLE, miss detected, stall.
  - cycles 1..`LINE_WORDS`: FILL, one ack per cycle.
  - cycle `LINE_WORDS`+1: IDLE, hit, stall low.
  - Defaults: penalty = 5 cycles.
- With N wait cycles per word, penalty = 1 + `LINE_WORDS`·(N+1) cycles.
- A `mem_ack` in the same cycle as `rst` is ignored.

## Structure
- Shared package `inst_cache_pkg`:
  - state enum (IDLE, FILL);
  - functions deriving `WORD_W`, `INDEX_W`, `TAG_W` from the parameters.
- One sub-module, `inst_cache_array`:
  - data and tag storage, combinational read, single write port (word write plus tag write);
  - valid bits stay in the top level so reset and flush are single-cycle.
- Top level: address split, hit compare, FSM, word counter, bus registers.

## Test plan
- Cold miss: reset, then `inst_ren`=1 at 0x0000_0040 with zero-wait memory. Expect requests at 0x40, 0x44, 0x48, 0x4C. Expect `inst_stall` high for exactly 5 cycles, then `inst_data` = the word at 0x40. Fetching 0x44..0x4C afterwards gives 0-cycle hits with no `mem_req`.
- Conflict eviction: fill 0x40, then fetch 0x440 (same index, tag 1). Expect a refill of 0x440..0x44C, then a fresh miss on 0x40.
- Backpressure: `mem_ack` delayed 3 cycles per word. Expect `mem_addr` stable while waiting and a penalty of 17 cycles. Data matches memory.
- Reset mid-fill: assert `rst` after the 2nd ack. Expect `mem_req` = 0 in the next cycle, a late ack ignored, and a miss again on re-fetching the same address.
- Flush: flush in IDLE after 0x40 is valid, then fetch 0x40 → expect a miss. Flush during FILL → expect the refill to complete but the same address to miss again.
- Address change during fill: switch `inst_addr` from 0x100 to 0x200 mid-FILL. Expect the 0x100 line to finish, then a new refill for 0x200. `inst_data` is never nonzero while stalled.
